// File: rtl/demux_1_2.sv
// Registered 1:2 packet demultiplexer: one valid/ready stream steered per packet
// into one of two independent output FIFOs, so a stalled output never blocks the other.
module demux_1_2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             s,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = WIDTH + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUTE0 = 2'd1;
  localparam logic [1:0] ROUTE1 = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_target;
  logic          w_accept;
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_full;
  logic [1:0]    w_valid;
  logic [EW-1:0] w_head [2];

  logic [PW-1:0] r_wr_ptr [2];
  logic [PW-1:0] r_rd_ptr [2];
  logic [PW-1:0] r_count  [2];
  logic [EW-1:0] r_mem    [2][DEPTH];
  logic [EW-1:0] r_hold   [2];

  assign w_ready = {out1_ready, out0_ready};

  // Route target: live select between packets, locked while a packet is in flight.
  always_comb begin
    w_target = 1'b0;
    w_push   = 2'b00;
    w_pop    = 2'b00;
    w_full   = 2'b00;
    w_valid  = 2'b00;
    w_head   = '{default: '0};
    w_target = (r_state == IDLE) ? s : (r_state == ROUTE1);
    for (int i = 0; i < 2; i++) begin
      w_full[i]  = (r_count[i] == PW'(DEPTH));
      w_valid[i] = (r_count[i] != '0);
      w_head[i]  = r_mem[i][r_rd_ptr[i][AW-1:0]];
      w_pop[i]   = w_valid[i] & w_ready[i];
    end
    in_ready = rst_n & ~w_full[w_target];
    w_accept = in_valid & in_ready;
    w_push[0] = w_accept & ~w_target;
    w_push[1] = w_accept & w_target;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        IDLE:           if (!in_last) w_state_nxt = s ? ROUTE1 : ROUTE0;
        ROUTE0, ROUTE1: if (in_last)  w_state_nxt = IDLE;
        default:        w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Per-output FIFO storage; r_hold keeps the last popped head visible once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
        r_hold[i]   <= '0;
        for (int j = 0; j < DEPTH; j++) r_mem[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wr_ptr[i][AW-1:0]] <= {in_data, in_last};
          r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
          r_hold[i]   <= w_head[i];
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + PW'(1);
          2'b01:   r_count[i] <= r_count[i] - PW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_valid[0] ? w_head[0][EW-1:1] : r_hold[0][EW-1:1];
  assign out0_last  = w_valid[0] ? w_head[0][0]      : r_hold[0][0];
  assign out1_data  = w_valid[1] ? w_head[1][EW-1:1] : r_hold[1][EW-1:1];
  assign out1_last  = w_valid[1] ? w_head[1][0]      : r_hold[1][0];
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_demux_1_2.sv
// Scoreboard bench for demux_1_2: driver queues expected beats per output,
// a negedge monitor pops and compares whenever an output beat is consumed.
module tb_demux_1_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, s, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out0_last, out0_ready;
  logic       out1_valid, out1_last, out1_ready;
  logic       busy;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int n_tests = 0;
  int n_fail  = 0;
  int waits;

  demux_1_2 #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .s(s),
    .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last),
    .out1_ready(out1_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic sel,
                      input int dest, output int nwait);
    bit done = 0;
    nwait = 0;
    in_data = d; in_last = l; s = sel; in_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (dest == 0) q0.push_back({d, l});
        else           q1.push_back({d, l});
        done = 1;
      end else begin
        nwait++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every consumed output beat must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("out0_unexpected", {23'd0, out0_data, out0_last}, 32'h1ff);
        else chk("out0_beat", {23'd0, out0_data, out0_last}, {23'd0, q0.pop_front()});
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected", {23'd0, out1_data, out1_last}, 32'h1ff);
        else chk("out1_beat", {23'd0, out1_data, out1_last}, {23'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; s = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out0_data", 32'(out0_data), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 1);

    // Single-beat packets
    @(posedge clk); #1;
    send(8'h11, 1'b1, 1'b0, 0, waits);
    chk("sb_out0_valid", 32'(out0_valid), 1);
    chk("sb_out0_data", 32'(out0_data), 32'h11);
    chk("sb_busy0", 32'(busy), 0);
    send(8'h22, 1'b1, 1'b1, 1, waits);
    chk("sb_out1_valid", 32'(out1_valid), 1);
    chk("sb_out1_data", 32'(out1_data), 32'h22);
    chk("sb_busy1", 32'(busy), 0);

    // Route hold with s toggling
    send(8'hA0, 1'b0, 1'b1, 1, waits);
    chk("rh_busy_b1", 32'(busy), 1);
    send(8'hA1, 1'b0, 1'b0, 1, waits);
    chk("rh_busy_b2", 32'(busy), 1);
    chk("rh_out0_idle", 32'(out0_valid), 0);
    send(8'hA2, 1'b1, 1'b1, 1, waits);
    chk("rh_busy_end", 32'(busy), 0);
    chk("rh_last_data", 32'(out1_data), 32'hA2);
    chk("rh_last_flag", 32'(out1_last), 1);
    idle(3);

    // Backpressure isolation
    out0_ready = 1'b0;
    send(8'h31, 1'b1, 1'b0, 0, waits);
    chk("bp_w1", 32'(waits), 0);
    send(8'h32, 1'b1, 1'b0, 0, waits);
    chk("bp_w2", 32'(waits), 0);
    in_data = 8'h33; in_last = 1'b1; s = 1'b0; in_valid = 1'b1;
    #1 chk("bp_full_ready", 32'(in_ready), 0);
    s = 1'b1;
    #1 chk("bp_other_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(8'h41, 1'b1, 1'b1, 1, waits);
    chk("bp_w_out1", 32'(waits), 0);
    out0_ready = 1'b1;
    in_data = 8'h33; in_last = 1'b1; s = 1'b0; in_valid = 1'b1;
    #1 chk("bp_no_fallthru", 32'(in_ready), 0);
    send(8'h33, 1'b1, 1'b0, 0, waits);
    chk("bp_recover_wait", 32'(waits), 1);
    idle(4);

    // Full FIFO with concurrent push/pop across wrap-around
    out0_ready = 1'b0;
    send(8'h50, 1'b1, 1'b0, 0, waits);
    send(8'h51, 1'b1, 1'b0, 0, waits);
    out0_ready = 1'b1;
    send(8'h52, 1'b1, 1'b0, 0, waits);
    chk("fp_full_wait", 32'(waits), 1);
    chk("fp_head_52", 32'(out0_data), 32'h52);
    for (int b = 8'h53; b <= 8'h59; b++) begin
      send(8'(b), 1'b1, 1'b0, 0, waits);
      chk("fp_wait", 32'(waits), 0);
      chk("fp_head", 32'(out0_data), 32'(b));
    end
    idle(4);
    chk("fp_drained", 32'(out0_valid), 0);

    // Reset mid-packet
    out1_ready = 1'b0;
    send(8'h61, 1'b0, 1'b1, 1, waits);
    send(8'h62, 1'b0, 1'b0, 1, waits);
    chk("rm_busy", 32'(busy), 1);
    chk("rm_out1_valid", 32'(out1_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_out1_cleared", 32'(out1_valid), 0);
    chk("rm_busy_cleared", 32'(busy), 0);
    chk("rm_in_ready", 32'(in_ready), 0);
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out1_ready = 1'b1;
    send(8'h71, 1'b1, 1'b0, 0, waits);
    chk("rm_out0_valid", 32'(out0_valid), 1);
    chk("rm_out0_data", 32'(out0_data), 32'h71);
    chk("rm_out1_empty", 32'(out1_valid), 0);
    idle(6);
    chk("rm_out1_stays_empty", 32'(out1_valid), 0);
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
